// File: rtl/rename_regs.sv
// Architectural register file with per-register rename state (busy + ROB tag).
// Rename/commit/flush update at the rising edge; reads use a registered address.
module rename_regs #(
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 6,
    parameter int NRD    = 8,
    parameter int NREN   = 4,
    parameter int NCMT   = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NRD*ADDR_W-1:0]            raddr,
    output logic [NRD*(DATA_W+1+TAG_W)-1:0]  rdata,
    input  logic [NREN-1:0]                  ren_en,
    input  logic [NREN*ADDR_W-1:0]           ren_addr,
    input  logic [NREN*TAG_W-1:0]            ren_tag,
    input  logic [NCMT-1:0]                  cmt_en,
    input  logic [NCMT*ADDR_W-1:0]           cmt_addr,
    input  logic [NCMT*DATA_W-1:0]           cmt_data,
    input  logic [NCMT*TAG_W-1:0]            cmt_tag,
    input  logic                             flush
);

    localparam int RW = DATA_W + 1 + TAG_W;

    logic [DATA_W-1:0] data_q [NREGS];
    logic [DATA_W-1:0] data_n [NREGS];
    logic [TAG_W-1:0]  tag_q  [NREGS];
    logic [TAG_W-1:0]  tag_n  [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_n;
    logic [NREGS-1:0]  cmt_hit;
    logic [NREGS-1:0]  ren_hit;
    logic [ADDR_W-1:0] raddr_q [NRD];

    // Ports are scanned in ascending order so the highest index overwrites;
    // matching against each in-range register drops out-of-range addresses.
    always_comb begin
        data_n  = data_q;
        tag_n   = tag_q;
        busy_n  = busy_q;
        cmt_hit = '0;
        ren_hit = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            for (int unsigned j = 0; j < NCMT; j++) begin
                if (cmt_en[j] && cmt_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    data_n[r]  = cmt_data[j*DATA_W +: DATA_W];
                    cmt_hit[r] = (tag_q[r] == cmt_tag[j*TAG_W +: TAG_W]);
                end
            end
            for (int unsigned i = 0; i < NREN; i++) begin
                if (ren_en[i] && ren_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    ren_hit[r] = 1'b1;
                    if (!flush)
                        tag_n[r] = ren_tag[i*TAG_W +: TAG_W];
                end
            end
            if (cmt_hit[r] && !ren_hit[r])
                busy_n[r] = 1'b0;
            if (ren_hit[r] && !flush)
                busy_n[r] = 1'b1;
            if (flush)
                busy_n[r] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int unsigned r = 0; r < NREGS; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            for (int unsigned k = 0; k < NRD; k++)
                raddr_q[k] <= '0;
        end else begin
            busy_q <= busy_n;
            for (int unsigned r = 0; r < NREGS; r++) begin
                data_q[r] <= data_n[r];
                tag_q[r]  <= tag_n[r];
            end
            for (int unsigned k = 0; k < NRD; k++)
                raddr_q[k] <= raddr[k*ADDR_W +: ADDR_W];
        end
    end

    // No bypass: reads see state as of the last edge.
    always_comb begin
        rdata = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                if (raddr_q[k] == ADDR_W'(r))
                    rdata[k*RW +: RW] = {data_q[r], busy_q[r], tag_q[r]};
            end
        end
    end

endmodule

// File: tb/tb_rename_regs.sv
// Directed self-checking bench for rename_regs: rename/commit priority, flush,
// multi-port reads and asynchronous reset.
module tb_rename_regs;

    localparam int NREGS  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 6;
    localparam int NRD    = 8;
    localparam int NREN   = 4;
    localparam int NCMT   = 3;
    localparam int RW     = DATA_W + 1 + TAG_W;

    logic                    clk;
    logic                    rst_n;
    logic [NRD*ADDR_W-1:0]   raddr;
    logic [NRD*RW-1:0]       rdata;
    logic [NREN-1:0]         ren_en;
    logic [NREN*ADDR_W-1:0]  ren_addr;
    logic [NREN*TAG_W-1:0]   ren_tag;
    logic [NCMT-1:0]         cmt_en;
    logic [NCMT*ADDR_W-1:0]  cmt_addr;
    logic [NCMT*DATA_W-1:0]  cmt_data;
    logic [NCMT*TAG_W-1:0]   cmt_tag;
    logic                    flush;

    int n_cmp = 0;
    int n_bad = 0;

    rename_regs #(
        .NREGS (NREGS),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TAG_W (TAG_W),
        .NRD   (NRD),
        .NREN  (NREN),
        .NCMT  (NCMT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr   (raddr),
        .rdata   (rdata),
        .ren_en  (ren_en),
        .ren_addr(ren_addr),
        .ren_tag (ren_tag),
        .cmt_en  (cmt_en),
        .cmt_addr(cmt_addr),
        .cmt_data(cmt_data),
        .cmt_tag (cmt_tag),
        .flush   (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] rd(input int k);
        return rdata[k*RW +: RW];
    endfunction

    function automatic logic [RW-1:0] trip(input logic [DATA_W-1:0] d, input logic b,
                                           input logic [TAG_W-1:0] t);
        return {d, b, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ren_en = '0; ren_addr = '0; ren_tag = '0;
        cmt_en = '0; cmt_addr = '0; cmt_data = '0; cmt_tag = '0;
        flush = 1'b0;
    endtask

    task automatic set_rd(input int k, input int a);
        raddr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic set_ren(input int i, input int a, input int t);
        ren_en[i] = 1'b1;
        ren_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
        ren_tag[i*TAG_W +: TAG_W] = TAG_W'(t);
    endtask

    task automatic set_cmt(input int j, input int a, input logic [DATA_W-1:0] d, input int t);
        cmt_en[j] = 1'b1;
        cmt_addr[j*ADDR_W +: ADDR_W] = ADDR_W'(a);
        cmt_data[j*DATA_W +: DATA_W] = d;
        cmt_tag[j*TAG_W +: TAG_W] = TAG_W'(t);
    endtask

    task automatic test_reset();
        logic [RW-1:0] got;
        rst_n = 1'b0;
        idle();
        for (int k = 0; k < NRD; k++) set_rd(k, k);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < NRD; k++) begin
            got = rd(k);
            n_cmp++;
            if (got !== '0) begin
                n_bad++;
                $display("FAIL reset_port%0d got %h expected %h", k, got, {RW{1'b0}});
            end
        end
        set_cmt(0, 3, 16'hBEEF, 0);
        set_rd(0, 3);
        tick();
        idle();
        got = rd(0);
        n_cmp++;
        if (got !== trip(16'hBEEF, 1'b0, 6'd0)) begin
            n_bad++;
            $display("FAIL first_commit_r3 got %h expected %h", got, trip(16'hBEEF, 1'b0, 6'd0));
        end
    endtask

    task automatic test_rename_priority();
        logic [RW-1:0] got;
        set_rd(0, 2);
        set_ren(0, 2, 5);
        set_ren(3, 2, 9);
        tick();
        idle();
        got = rd(0);
        n_cmp++;
        if (got !== trip(16'h0, 1'b1, 6'd9)) begin
            n_bad++;
            $display("FAIL ren_same_addr got %h expected %h", got, trip(16'h0, 1'b1, 6'd9));
        end
        set_cmt(1, 2, 16'h1234, 5);
        tick();
        idle();
        got = rd(0);
        n_cmp++;
        if (got !== trip(16'h1234, 1'b1, 6'd9)) begin
            n_bad++;
            $display("FAIL stale_tag_commit got %h expected %h", got, trip(16'h1234, 1'b1, 6'd9));
        end
        set_cmt(2, 2, 16'h5678, 9);
        tick();
        idle();
        got = rd(0);
        n_cmp++;
        if (got !== trip(16'h5678, 1'b0, 6'd9)) begin
            n_bad++;
            $display("FAIL match_tag_commit got %h expected %h", got, trip(16'h5678, 1'b0, 6'd9));
        end
    endtask

    task automatic test_rename_vs_commit();
        logic [RW-1:0] got;
        set_rd(1, 4);
        set_ren(1, 4, 7);
        tick();
        idle();
        got = rd(1);
        n_cmp++;
        if (got !== trip(16'h0, 1'b1, 6'd7)) begin
            n_bad++;
            $display("FAIL ren_r4 got %h expected %h", got, trip(16'h0, 1'b1, 6'd7));
        end
        set_cmt(0, 4, 16'h4444, 7);
        set_ren(2, 4, 12);
        tick();
        idle();
        got = rd(1);
        n_cmp++;
        if (got !== trip(16'h4444, 1'b1, 6'd12)) begin
            n_bad++;
            $display("FAIL ren_beats_cmt got %h expected %h", got, trip(16'h4444, 1'b1, 6'd12));
        end
    endtask

    task automatic test_commit_tag_priority();
        logic [RW-1:0] got;
        set_rd(2, 6);
        set_ren(0, 6, 4);
        tick();
        idle();
        // Port 0 carries the matching tag but port 1 is younger and does not match.
        set_cmt(0, 6, 16'h000A, 4);
        set_cmt(1, 6, 16'h000B, 5);
        tick();
        idle();
        got = rd(2);
        n_cmp++;
        if (got !== trip(16'h000B, 1'b1, 6'd4)) begin
            n_bad++;
            $display("FAIL cmt_tag_priority got %h expected %h", got, trip(16'h000B, 1'b1, 6'd4));
        end
        set_cmt(0, 6, 16'h0000, 4);
        tick();
        idle();
        got = rd(2);
        n_cmp++;
        if (got !== trip(16'h0000, 1'b0, 6'd4)) begin
            n_bad++;
            $display("FAIL cmt_r6_clear got %h expected %h", got, trip(16'h0000, 1'b0, 6'd4));
        end
    endtask

    task automatic test_flush();
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        set_ren(0, 1, 1);
        set_ren(1, 5, 2);
        set_ren(2, 6, 3);
        set_rd(0, 1);
        tick();
        idle();
        got = rd(0);
        n_cmp++;
        if (got !== trip(16'h0, 1'b1, 6'd1)) begin
            n_bad++;
            $display("FAIL pre_flush_r1 got %h expected %h", got, trip(16'h0, 1'b1, 6'd1));
        end
        flush = 1'b1;
        set_ren(0, 0, 3);
        set_cmt(0, 5, 16'h00AA, 0);
        set_rd(0, 0);
        set_rd(1, 1);
        set_rd(2, 5);
        set_rd(3, 6);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: exp = trip(16'h0000, 1'b0, 6'd0);
                1: exp = trip(16'h0000, 1'b0, 6'd1);
                2: exp = trip(16'h00AA, 1'b0, 6'd2);
                default: exp = trip(16'h0000, 1'b0, 6'd3);
            endcase
            got = rd(k);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL flush_port%0d got %h expected %h", k, got, exp);
            end
        end
    endtask

    task automatic test_multi_port();
        logic [RW-1:0] got;
        logic [RW-1:0] exp [NREGS];
        exp[0] = trip(16'h0000, 1'b0, 6'd0);
        exp[1] = trip(16'h0000, 1'b0, 6'd1);
        exp[2] = trip(16'h5678, 1'b0, 6'd9);
        exp[3] = trip(16'hBEEF, 1'b0, 6'd0);
        exp[4] = trip(16'h4444, 1'b0, 6'd12);
        exp[5] = trip(16'h00AA, 1'b0, 6'd2);
        exp[6] = trip(16'h0000, 1'b0, 6'd3);
        exp[7] = trip(16'h2222, 1'b0, 6'd0);
        set_cmt(0, 7, 16'h1111, 0);
        set_cmt(2, 7, 16'h2222, 0);
        for (int k = 0; k < NRD; k++) set_rd(k, NREGS - 1 - k);
        tick();
        idle();
        for (int k = 0; k < NRD; k++) begin
            got = rd(k);
            n_cmp++;
            if (got !== exp[NREGS-1-k]) begin
                n_bad++;
                $display("FAIL multi_read_port%0d got %h expected %h", k, got, exp[NREGS-1-k]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [RW-1:0] got;
        set_rd(0, 3);
        set_ren(0, 3, 10);
        tick();
        idle();
        got = rd(0);
        n_cmp++;
        if (got !== trip(16'hBEEF, 1'b1, 6'd10)) begin
            n_bad++;
            $display("FAIL pre_areset_r3 got %h expected %h", got, trip(16'hBEEF, 1'b1, 6'd10));
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = rd(0);
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL areset_midcycle got %h expected %h", got, {RW{1'b0}});
        end
        tick();
        #3;
        rst_n = 1'b1;
        set_rd(0, 3);
        set_cmt(0, 3, 16'h0F0F, 0);
        tick();
        idle();
        got = rd(0);
        n_cmp++;
        if (got !== trip(16'h0F0F, 1'b0, 6'd0)) begin
            n_bad++;
            $display("FAIL post_areset_commit got %h expected %h", got, trip(16'h0F0F, 1'b0, 6'd0));
        end
    endtask

    initial begin
        raddr = '0;
        idle();
        rst_n = 1'b0;
        test_reset();
        test_rename_priority();
        test_rename_vs_commit();
        test_commit_tag_priority();
        test_flush();
        test_multi_port();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
